// File: rtl/imem_loader.sv
// imem_loader: runtime program loader for the instruction memory.
//
// Accepts a framed byte stream (LEN_LO, LEN_HI, 4*N data bytes, CSUM) over a
// valid/ready handshake. It assembles little-endian 32-bit words and writes
// them to consecutive word addresses starting at BASE_ADDR. CSUM is the XOR
// of the data bytes only.
//
// Ports:
//   clk, reset      - clock and synchronous active-high reset
//   start           - begin a load (honoured only in IDLE, DONE or ERR)
//   in_valid/in_data/in_ready - byte stream handshake
//   mem_we/mem_addr/mem_wdata - registered instruction memory write port
//   busy, done, error - load status; done/error are sticky until next start
//   words_loaded    - words written in the current or last load
module imem_loader #(
  parameter int ADDR_WIDTH = 10,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH-2:0] words_loaded
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN0, S_LEN1, S_DATA, S_WRITE, S_CSUM, S_DONE, S_ERR
  } state_t;

  // Words that fit between BASE_ADDR and the top of memory.
  localparam logic [16:0] CAPACITY = 17'(2 ** (ADDR_WIDTH - 2) - BASE_ADDR / 4);

  state_t                state_reg, state_next;
  logic [15:0]           len_reg;
  logic [1:0]            byte_idx_reg;
  logic [7:0]            csum_reg;
  logic [ADDR_WIDTH-1:0] ptr_reg;
  logic [ADDR_WIDTH-2:0] words_reg;
  logic                  in_ready_reg, mem_we_reg, busy_reg, done_reg, error_reg;

  logic        accept;
  logic        overflow;
  logic        last_word;
  logic [16:0] words_plus1;

  assign accept      = in_valid && in_ready_reg;
  // Evaluated in LEN1 with the high byte still on in_data.
  assign overflow    = {1'b0, in_data, len_reg[7:0]} > CAPACITY;
  assign words_plus1 = 17'(words_reg) + 17'd1;
  assign last_word   = (words_plus1 == {1'b0, len_reg});

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE, S_DONE, S_ERR: if (start) state_next = S_LEN0;
      S_LEN0:  if (accept) state_next = S_LEN1;
      S_LEN1: begin
        if (accept) begin
          if (overflow)                          state_next = S_ERR;
          else if ({in_data, len_reg[7:0]} == 16'd0) state_next = S_CSUM;
          else                                   state_next = S_DATA;
        end
      end
      S_DATA:  if (accept && byte_idx_reg == 2'd3) state_next = S_WRITE;
      S_WRITE: state_next = last_word ? S_CSUM : S_DATA;
      S_CSUM: begin
        if (accept) state_next = (in_data == csum_reg) ? S_DONE : S_ERR;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= S_IDLE;
      len_reg      <= '0;
      byte_idx_reg <= '0;
      csum_reg     <= '0;
      ptr_reg      <= ADDR_WIDTH'(BASE_ADDR);
      words_reg    <= '0;
      in_ready_reg <= 1'b0;
      mem_we_reg   <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      error_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      // Status/handshake flags are registered copies decoded from the next
      // state, so they line up exactly with the state they describe.
      in_ready_reg <= (state_next == S_LEN0) || (state_next == S_LEN1) ||
                      (state_next == S_DATA) || (state_next == S_CSUM);
      busy_reg     <= (state_next == S_LEN0) || (state_next == S_LEN1) ||
                      (state_next == S_DATA) || (state_next == S_WRITE) ||
                      (state_next == S_CSUM);
      mem_we_reg   <= (state_next == S_WRITE);
      done_reg     <= (state_next == S_DONE);
      error_reg    <= (state_next == S_ERR);

      case (state_reg)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            words_reg    <= '0;
            byte_idx_reg <= '0;
            csum_reg     <= '0;
            ptr_reg      <= ADDR_WIDTH'(BASE_ADDR);
          end
        end
        S_LEN0: if (accept) len_reg[7:0]  <= in_data;
        S_LEN1: if (accept) len_reg[15:8] <= in_data;
        S_DATA: begin
          if (accept) begin
            csum_reg     <= csum_reg ^ in_data;
            byte_idx_reg <= byte_idx_reg + 2'd1;
          end
        end
        S_WRITE: begin
          words_reg    <= words_reg + 1'b1;
          byte_idx_reg <= '0;
          // Holding the pointer after the final word keeps mem_addr from
          // wrapping to 0 when the load fills memory to the top.
          if (!last_word) ptr_reg <= ptr_reg + ADDR_WIDTH'(4);
        end
        default: ;
      endcase
    end
  end

  // One assembly lane per byte position; lane gi takes the gi-th byte of a word.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_reg;
      always_ff @(posedge clk) begin
        if (reset) begin
          lane_reg <= '0;
        end else if (state_reg == S_DATA && accept && byte_idx_reg == 2'(gi)) begin
          lane_reg <= in_data;
        end
      end
      assign mem_wdata[gi*8 +: 8] = lane_reg;
    end
  endgenerate

  assign in_ready     = in_ready_reg;
  assign mem_we       = mem_we_reg;
  assign mem_addr     = ptr_reg;
  assign busy         = busy_reg;
  assign done         = done_reg;
  assign error        = error_reg;
  assign words_loaded = words_reg;

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;
  localparam int AW   = 10;
  localparam int BASE = 0;
  localparam int CAP  = 2 ** (AW - 2) - BASE / 4;

  logic          clk = 1'b0;
  logic          reset, start, in_valid;
  logic [7:0]    in_data;
  logic          in_ready, mem_we, busy, done, error;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [AW-2:0] words_loaded;

  imem_loader #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy), .done(done),
    .error(error), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          addr;
    logic [31:0] data;
  } wr_t;
  wr_t wr_q[$];

  logic [7:0]  frame_q[$];
  logic [31:0] exp_words_q[$];

  typedef struct {
    int         n;
    logic [7:0] csum_mask;
    int         throttle;
    bit         exp_done;
    bit         exp_error;
    int         exp_words;
  } vec_t;

  // Write monitor: every write is logged, and in_ready must be low while writing.
  always @(negedge clk) begin
    if (!reset && mem_we) begin
      wr_q.push_back('{int'(mem_addr), mem_wdata});
      checks++;
      if (in_ready !== 1'b0) begin
        errors++;
        $display("FAIL in_ready_in_write got %0b need 0", in_ready);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h need %0h", name, got, exp);
    end
  endtask

  // Reference frame: random words, split little-endian into bytes, XOR of data only.
  task automatic build(input int n, input logic [7:0] mask);
    logic [31:0] word;
    logic [7:0]  x;
    logic [7:0]  b;
    x = 8'h00;
    frame_q.delete();
    exp_words_q.delete();
    frame_q.push_back(n[7:0]);
    frame_q.push_back(n[15:8]);
    if (n <= CAP) begin
      for (int i = 0; i < n; i++) begin
        word = $urandom;
        exp_words_q.push_back(word);
        for (int k = 0; k < 4; k++) begin
          b = 8'((word >> (8 * k)) & 32'hFF);
          frame_q.push_back(b);
          x = x ^ b;
        end
      end
      frame_q.push_back(x ^ mask);
    end
  endtask

  task automatic do_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic drive(input int throttle, input bit rnd_start,
                       output int first_acc, output int last_acc, output bit timeout);
    int idx;
    int guard;
    bit acc;
    idx = 0; guard = 0; first_acc = -1; last_acc = -1; timeout = 1'b0;
    while (idx < frame_q.size()) begin
      @(negedge clk);
      case (throttle)
        0:       in_valid = 1'b1;
        1:       in_valid = (guard % 2 == 0);
        default: in_valid = 1'($urandom % 2);
      endcase
      in_data = frame_q[idx];
      start   = rnd_start ? ($urandom % 6 == 0) : 1'b0;
      acc     = in_valid && in_ready;
      if (acc) begin
        if (first_acc < 0) first_acc = cyc;
        last_acc = cyc;
      end
      @(posedge clk);
      if (acc) idx++;
      guard++;
      if (guard > 5000) begin
        timeout = 1'b1;
        break;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    start    = 1'b0;
  endtask

  task automatic run_built(input string tag, input int n, input int thr, input bit rs,
                           input bit ed, input bit ee, input int ew);
    int  f, l, nexp;
    bit  to;
    wr_q.delete();
    do_start();
    drive(thr, rs, f, l, to);
    chk({tag, "_timeout"}, 32'(to), 32'd0);
    chk({tag, "_done"},  32'(done),  32'(ed));
    chk({tag, "_error"}, 32'(error), 32'(ee));
    chk({tag, "_words"}, 32'(words_loaded), 32'(ew));
    if (thr == 0 && !to)
      chk({tag, "_latency"}, 32'(l - f), (n > CAP) ? 32'd1 : 32'(2 + 5 * n));
    nexp = exp_words_q.size();
    chk({tag, "_nwrites"}, 32'(wr_q.size()), 32'(nexp));
    for (int i = 0; i < nexp && i < wr_q.size(); i++) begin
      chk({tag, "_addr"}, 32'(wr_q[i].addr), 32'(BASE + 4 * i));
      chk({tag, "_data"}, wr_q[i].data, exp_words_q[i]);
    end
    repeat (2) @(negedge clk);
    chk({tag, "_ready_after"}, 32'(in_ready), 32'd0);
    chk({tag, "_sticky"}, 32'({done, error}), 32'({ed, ee}));
    $display("frame %s n=%0d writes=%0d done=%0b error=%0b words=%0d",
             tag, n, wr_q.size(), done, error, words_loaded);
  endtask

  vec_t tbl[8];

  initial begin
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(in_ready), 32'd0);
    chk("rst_we",    32'(mem_we),   32'd0);
    chk("rst_addr",  32'(mem_addr), 32'(BASE));
    chk("rst_wdata", mem_wdata,     32'd0);
    chk("rst_flags", 32'({busy, done, error}), 32'd0);
    chk("rst_words", 32'(words_loaded), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Literal single-word frame.
    frame_q = '{8'h01, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'hB6};
    exp_words_q = '{32'h00A00513};
    run_built("spec1", 1, 0, 1'b0, 1'b1, 1'b0, 1);

    // Literal single-word frame with a bad checksum.
    frame_q = '{8'h01, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h00};
    exp_words_q = '{32'h00A00513};
    run_built("badcs", 1, 0, 1'b0, 1'b0, 1'b1, 1);

    tbl[0] = '{1,   8'h00, 0, 1'b1, 1'b0, 1};
    tbl[1] = '{2,   8'h00, 1, 1'b1, 1'b0, 2};
    tbl[2] = '{1,   8'hFF, 0, 1'b0, 1'b1, 1};
    tbl[3] = '{257, 8'h00, 0, 1'b0, 1'b1, 0};
    tbl[4] = '{0,   8'h00, 0, 1'b1, 1'b0, 0};
    tbl[5] = '{256, 8'h00, 0, 1'b1, 1'b0, 256};
    tbl[6] = '{3,   8'h00, 2, 1'b1, 1'b0, 3};
    tbl[7] = '{5,   8'h01, 2, 1'b0, 1'b1, 5};
    for (int i = 0; i < 8; i++) begin
      build(tbl[i].n, tbl[i].csum_mask);
      run_built($sformatf("tbl%0d", i), tbl[i].n, tbl[i].throttle, 1'b0,
                tbl[i].exp_done, tbl[i].exp_error, tbl[i].exp_words);
    end

    // Random frames with stray start pulses while busy.
    for (int i = 0; i < 10; i++) begin
      int n;
      bit bad;
      logic [7:0] m;
      n   = $urandom_range(0, 6);
      bad = ($urandom % 3 == 0);
      m   = bad ? 8'($urandom_range(1, 255)) : 8'h00;
      build(n, m);
      run_built($sformatf("rnd%0d", i), n, int'($urandom % 3), 1'b1, !bad, bad, n);
    end

    // Reset after two data bytes, then a clean reload from BASE.
    build(2, 8'h00);
    while (frame_q.size() > 4) void'(frame_q.pop_back());
    wr_q.delete();
    begin
      int f, l;
      bit to;
      do_start();
      drive(0, 1'b0, f, l, to);
      chk("mid_timeout", 32'(to), 32'd0);
    end
    reset = 1'b1;
    @(negedge clk);
    chk("mid_ready", 32'(in_ready), 32'd0);
    chk("mid_flags", 32'({busy, done, error, mem_we}), 32'd0);
    chk("mid_addr",  32'(mem_addr), 32'(BASE));
    chk("mid_wdata", mem_wdata, 32'd0);
    chk("mid_words", 32'(words_loaded), 32'd0);
    chk("mid_nowr",  32'(wr_q.size()), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    build(1, 8'h00);
    run_built("reload", 1, 0, 1'b0, 1'b1, 1'b0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
